// File: rtl/picomips_pkg.sv
// Shared picoMIPS definitions: opcode encoding, sequencer states and default sizes.
package picomips_pkg;

    localparam int PSIZE_DEF    = 6;
    localparam int OSIZE_DEF    = 4;
    localparam int DBCYCLES_DEF = 16;

    typedef enum logic [3:0] {
        OP_NOP  = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_ADDI = 4'b0010,
        OP_MULI = 4'b0011,
        OP_JMP  = 4'b1000,
        OP_BEQ  = 4'b1001,
        OP_BNE  = 4'b1010,
        OP_WAIT = 4'b1011,
        OP_HALT = 4'b1111
    } opcode_t;

    typedef enum logic [1:0] {
        RUN          = 2'd0,
        WAIT_PRESS   = 2'd1,
        WAIT_RELEASE = 2'd2,
        HALT         = 2'd3
    } seq_state_t;

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioning: two-flop synchroniser, plus a stable-count debounce
// when PCSEQ_DEBOUNCE_EN is defined (otherwise btn_c follows the synchroniser).
module btn_conditioner
    import picomips_pkg::*;
#(
`ifdef PCSEQ_DEBOUNCE_EN
    parameter int DBcycles = DBCYCLES_DEF
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic btn_c
);

    logic sync1_q, btn_s_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            btn_s_q <= 1'b0;
        end else begin
            sync1_q <= button;
            btn_s_q <= sync1_q;
        end
    end

`ifdef PCSEQ_DEBOUNCE_EN
    localparam int CW = $clog2(DBcycles + 1);

    logic [CW-1:0] cnt_q;
    logic          btn_c_q;

    // btn_c flips only once btn_s has disagreed with it for DBcycles cycles in a row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            btn_c_q <= 1'b0;
        end else if (btn_s_q == btn_c_q) begin
            cnt_q   <= '0;
        end else if (cnt_q == CW'(DBcycles - 1)) begin
            cnt_q   <= '0;
            btn_c_q <= btn_s_q;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign btn_c = btn_c_q;
`else
    assign btn_c = btn_s_q;
`endif

endmodule

// File: rtl/pc_sequencer.sv
// picoMIPS PC sequencer: branch decode, WAIT-for-button and HALT control.
// Optional button debounce is enabled with PCSEQ_DEBOUNCE_EN.
module pc_sequencer
    import picomips_pkg::*;
#(
    parameter int Psize = PSIZE_DEF,
    parameter int Osize = OSIZE_DEF
`ifdef PCSEQ_DEBOUNCE_EN
   ,parameter int DBcycles = DBCYCLES_DEF
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Osize-1:0] opcode,
    input  logic [Psize-1:0] branch_target,
    input  logic             zero,
    input  logic             run_en,
    input  logic             button,
    output logic             PCincr,
    output logic             PCabsbranch,
    output logic [Psize-1:0] Branchaddr,
    output logic             stall,
    output logic             waiting,
    output logic             halted
);

    seq_state_t state_q, state_d;
    logic       btn_c;
    logic       incr, absbr;

`ifdef PCSEQ_DEBOUNCE_EN
    btn_conditioner #(.DBcycles(DBcycles)) u_btn (
`else
    btn_conditioner u_btn (
`endif
        .clk   (clk),
        .reset (reset),
        .button(button),
        .btn_c (btn_c)
    );

    always_comb begin
        incr    = 1'b0;
        absbr   = 1'b0;
        state_d = state_q;
        if (!reset) begin
            case (state_q)
                RUN: begin
                    if (run_en) begin
                        case (opcode)
                            Osize'(OP_JMP):  absbr = 1'b1;
                            Osize'(OP_BEQ):  begin absbr = zero;  incr = ~zero; end
                            Osize'(OP_BNE):  begin absbr = ~zero; incr = zero;  end
                            Osize'(OP_WAIT): state_d = WAIT_PRESS;
                            Osize'(OP_HALT): state_d = HALT;
                            default:         incr = 1'b1;
                        endcase
                    end
                end
                WAIT_PRESS: begin
                    if (btn_c) state_d = WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    // The release completes the WAIT: step past it this cycle.
                    if (!btn_c) begin
                        incr    = 1'b1;
                        state_d = RUN;
                    end
                end
                HALT:    state_d = HALT;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    assign PCincr      = incr;
    assign PCabsbranch = absbr;
    assign Branchaddr  = absbr ? branch_target : '0;
    assign stall       = ~(incr | absbr);
    assign waiting     = (state_q == WAIT_PRESS) || (state_q == WAIT_RELEASE);
    assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver predicts each cycle's outputs from a
// behavioural model, a separate monitor pops and compares them before the edge.
module tb_pc_sequencer;
    import picomips_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'd0;
    logic [5:0] branch_target = 6'd0;
    logic       zero = 1'b0, run_en = 1'b0, button = 1'b0;
    logic       PCincr, PCabsbranch, stall, waiting, halted;
    logic [5:0] Branchaddr;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .branch_target(branch_target),
        .zero(zero), .run_en(run_en), .button(button),
        .PCincr(PCincr), .PCabsbranch(PCabsbranch), .Branchaddr(Branchaddr),
        .stall(stall), .waiting(waiting), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit incr;
        bit absb;
        int addr;
        bit stall;
        bit waiting;
        bit halted;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Model: mode 0=running, 1=awaiting press, 2=awaiting release, 3=halted.
    int   mode = 0;
    bit   raw_hist[$];

    function automatic bit model_btn();
        // The conditioned button is the raw button as sampled two edges ago.
        if (raw_hist.size() >= 2) return raw_hist[raw_hist.size()-2];
        return 1'b0;
    endfunction

    task automatic step(input logic [3:0] op, input logic [5:0] tgt, input bit z,
                        input bit ren, input bit btn, input bit rst);
        exp_t e;
        int   act, nm;
        bit   bc;
        @(negedge clk); #1;
        opcode = op; branch_target = tgt; zero = z; run_en = ren; button = btn; reset = rst;
        bc  = model_btn();
        act = 0;  // 0 = PC holds, 1 = step, 2 = jump
        nm  = mode;
        if (!rst) begin
            if (mode == 1) begin
                if (bc) nm = 2;
            end else if (mode == 2) begin
                if (!bc) begin act = 1; nm = 0; end
            end else if (mode == 0 && ren) begin
                if (op == OP_WAIT)      nm = 1;
                else if (op == OP_HALT) nm = 3;
                else if (op == OP_JMP || (op == OP_BEQ && z) || (op == OP_BNE && !z)) act = 2;
                else act = 1;
            end
        end
        e.incr    = (act == 1);
        e.absb    = (act == 2);
        e.addr    = (act == 2) ? int'(tgt) : 0;
        e.stall   = (act == 0);
        e.waiting = !rst && (mode == 1 || mode == 2);
        e.halted  = !rst && (mode == 3);
        sb.push_back(e);
        @(posedge clk);
        if (rst) begin
            mode = 0;
            raw_hist.delete();
        end else begin
            mode = nm;
            raw_hist.push_back(btn);
            if (raw_hist.size() > 4) void'(raw_hist.pop_front());
        end
    endtask

    // Monitor: compare just before each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #4;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (PCincr !== e.incr || PCabsbranch !== e.absb || Branchaddr !== 6'(e.addr) ||
                    stall !== e.stall || waiting !== e.waiting || halted !== e.halted) begin
                    errors++;
                    $display("FAIL outputs t=%0t got incr=%b abs=%b addr=%0d stall=%b wait=%b halt=%b exp incr=%b abs=%b addr=%0d stall=%b wait=%b halt=%b",
                             $time, PCincr, PCabsbranch, Branchaddr, stall, waiting, halted,
                             e.incr, e.absb, e.addr, e.stall, e.waiting, e.halted);
                end
            end
        end
    end

    initial begin
        logic [3:0] rop;
        bit         rbtn;

        step(OP_NOP, 6'd0, 0, 1, 0, 1);
        step(OP_NOP, 6'd0, 0, 1, 0, 1);

        for (int i = 0; i < 4; i++) step(OP_ADD, 6'd5, 0, 1, 0, 0);
        step(OP_BEQ, 6'd42, 1, 1, 0, 0);
        step(OP_BEQ, 6'd42, 0, 1, 0, 0);
        step(OP_BNE, 6'd42, 0, 1, 0, 0);
        step(OP_BNE, 6'd42, 1, 1, 0, 0);
        step(OP_JMP, 6'd63, 1, 1, 0, 0);
        step(OP_ADD, 6'd9, 0, 0, 0, 0);

        // WAIT with a press over cycles 10..19 after decode.
        step(OP_WAIT, 6'd0, 0, 1, 0, 0);
        for (int c = 1; c <= 26; c++) step(OP_NOP, 6'd0, 0, (c % 3) != 0, (c >= 10 && c < 20), 0);

        // WAIT entered with the button already held.
        step(OP_WAIT, 6'd0, 0, 1, 1, 0);
        for (int c = 1; c <= 8; c++) step(OP_NOP, 6'd0, 0, 1, c < 5, 0);

        rbtn = 0;
        for (int i = 0; i < 400; i++) begin
            rop = 4'($urandom_range(0, 15));
            if (rop == OP_HALT) rop = OP_NOP;
            if ($urandom_range(0, 5) == 0) rbtn = ~rbtn;
            step(rop, 6'($urandom), 1'($urandom), $urandom_range(0, 9) != 0, rbtn, 0);
        end
        step(OP_NOP, 6'd0, 0, 1, 0, 1);

        // Reset while awaiting release, then a frozen RUN.
        step(OP_WAIT, 6'd0, 0, 1, 0, 0);
        for (int c = 0; c < 5; c++) step(OP_NOP, 6'd0, 0, 1, 1, 0);
        step(OP_NOP, 6'd0, 0, 1, 1, 1);
        for (int c = 0; c < 3; c++) step(OP_ADD, 6'd0, 0, 0, 0, 0);

        step(OP_HALT, 6'd0, 0, 1, 0, 0);
        for (int i = 0; i < 50; i++)
            step(4'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);

        // Asynchronous exit from HALT, mid-cycle.
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (halted !== 1'b0 || stall !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got halted=%b stall=%b exp halted=0 stall=1", halted, stall);
        end
        @(posedge clk);
        mode = 0;
        raw_hist.delete();
        step(OP_NOP, 6'd0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) step(OP_ADDI, 6'd0, 0, 1, 0, 0);

        @(negedge clk); #6;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
